// File: rtl/chip_link_receiver_pkg.sv
// chip_link_pkg: shared definitions for the chip-side serial link receiver.
//   key_state_t  - write-key qualification FSM states
//   SYNC_STAGES  - depth of every input synchronizer
//   cnt_width()  - width of a counter that must hold the values 0..n
package chip_link_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    K_IDLE,
    K_QUAL,
    K_LATCH,
    K_HELD
  } key_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/chip_link_receiver_if.sv
// chip_link_receiver_if: bundle of the serial link inputs and the receiver
// results.
//   i_clk_col/i_data_col, i_clk_row/i_data_row - serial clocks and data
//   i_write_key                                - latch strobe, active-high
//   o_col_shift/o_row_shift                    - live shift registers
//   o_col_q/o_row_q                            - words held at the last latch
//   o_latch_valid/o_count_err/o_overrun        - latch status
//   key_state/sync_levels                      - debug visibility
// Handshake: there is no back-pressure. o_latch_valid is a one-cycle pulse
// issued in the same cycle o_col_q/o_row_q change; o_count_err is only
// meaningful while o_latch_valid is high and reads 0 otherwise.
interface chip_link_receiver_if #(
  parameter int N_COL = 16,
  parameter int N_ROW = 16
);
  import chip_link_pkg::*;

  logic             i_clk_col;
  logic             i_data_col;
  logic             i_clk_row;
  logic             i_data_row;
  logic             i_write_key;
  logic [N_COL-1:0] o_col_shift;
  logic [N_ROW-1:0] o_row_shift;
  logic [N_COL-1:0] o_col_q;
  logic [N_ROW-1:0] o_row_q;
  logic             o_latch_valid;
  logic             o_count_err;
  logic             o_overrun;
  key_state_t       key_state;
  logic [2:0]       sync_levels;  // {key, row clk, col clk} synchronized

  modport master (
    output i_clk_col, i_data_col, i_clk_row, i_data_row, i_write_key,
    input  o_col_shift, o_row_shift, o_col_q, o_row_q,
    input  o_latch_valid, o_count_err, o_overrun, key_state, sync_levels
  );

  modport slave (
    input  i_clk_col, i_data_col, i_clk_row, i_data_row, i_write_key,
    output o_col_shift, o_row_shift, o_col_q, o_row_q,
    output o_latch_valid, o_count_err, o_overrun, key_state, sync_levels
  );

endinterface

// File: rtl/chip_link_receiver_edge_sync.sv
// edge_sync: SYNC_STAGES-deep synchronizer for one asynchronous line.
//   clk, rst - system clock, asynchronous active-low reset
//   din      - asynchronous input
//   level    - synchronized level
//   rise     - registered one-cycle pulse on a synchronized rising edge
// rise is formed from the last two sync stages, so it goes high in the same
// cycle level first reads 1.
module edge_sync
  import chip_link_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
      rise <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      rise <= sync[SYNC_STAGES-2] & ~sync[SYNC_STAGES-1];
    end
  end

  assign level = sync[SYNC_STAGES-1];

endmodule

// File: rtl/chip_link_receiver.sv
// chip_link_receiver: oversamples the serial configuration link, shifts the
// column/row data into shift registers and, on a qualified write-key pulse,
// latches both words and reports whether each frame had the expected length.
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   link - chip_link_receiver_if.slave (serial inputs, results, debug)
module chip_link_receiver
  import chip_link_pkg::*;
#(
  parameter int N_COL   = 16,
  parameter int N_ROW   = 16,
  parameter int KEY_MIN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  chip_link_receiver_if.slave  link
);

  localparam int CCW = cnt_width(N_COL);
  localparam int RCW = cnt_width(N_ROW);
  localparam int QW  = cnt_width(KEY_MIN);

  logic col_level, col_rise;
  logic row_level, row_rise;
  logic key_level, key_rise;

  edge_sync u_col_sync (.clk(clk), .rst(rst), .din(link.i_clk_col),
                        .level(col_level), .rise(col_rise));
  edge_sync u_row_sync (.clk(clk), .rst(rst), .din(link.i_clk_row),
                        .level(row_level), .rise(row_rise));
  edge_sync u_key_sync (.clk(clk), .rst(rst), .din(link.i_write_key),
                        .level(key_level), .rise(key_rise));

  // Data lines use the same depth as their clocks; the clock's registered
  // rise pulse lines up with the data sampled at the serial-clock edge.
  logic [SYNC_STAGES-1:0] dcol_sync, drow_sync;
  logic                   data_col, data_row;

  assign data_col = dcol_sync[SYNC_STAGES-1];
  assign data_row = drow_sync[SYNC_STAGES-1];

  logic [N_COL-1:0] col_shift, col_shift_next, col_q;
  logic [N_ROW-1:0] row_shift, row_shift_next, row_q;
  logic [CCW-1:0]   col_cnt, col_cnt_next;
  logic [RCW-1:0]   row_cnt, row_cnt_next;
  logic             col_ovr, row_ovr;
  logic             overrun, latch_valid, count_err;

  key_state_t state, state_next;
  logic [QW-1:0] qcnt, qcnt_next;
  logic          do_latch;

  // Shift datapath: counters saturate at N, a further edge flags overrun
  // but the bit is still shifted in.
  always_comb begin
    col_shift_next = col_shift;
    col_cnt_next   = col_cnt;
    col_ovr        = 1'b0;
    row_shift_next = row_shift;
    row_cnt_next   = row_cnt;
    row_ovr        = 1'b0;
    if (col_rise) begin
      col_shift_next = {col_shift[N_COL-2:0], data_col};
      if (col_cnt == CCW'(N_COL)) col_ovr = 1'b1;
      else                        col_cnt_next = col_cnt + 1'b1;
    end
    if (row_rise) begin
      row_shift_next = {row_shift[N_ROW-2:0], data_row};
      if (row_cnt == RCW'(N_ROW)) row_ovr = 1'b1;
      else                        row_cnt_next = row_cnt + 1'b1;
    end
  end

  // Key FSM. The IDLE cycle that sees the rise already has the key high,
  // so in QUAL the key has been high for qcnt + 2 synchronized cycles.
  always_comb begin
    state_next = state;
    qcnt_next  = qcnt;
    do_latch   = 1'b0;
    unique case (state)
      K_IDLE: begin
        if (key_rise) begin
          state_next = K_QUAL;
          qcnt_next  = '0;
        end
      end
      K_QUAL: begin
        if (!key_level)                    state_next = K_IDLE;
        else if (int'(qcnt) + 2 >= KEY_MIN) state_next = K_LATCH;
        else                               qcnt_next  = qcnt + 1'b1;
      end
      K_LATCH: begin
        do_latch   = 1'b1;
        state_next = K_HELD;
      end
      K_HELD: begin
        if (!key_level) state_next = K_IDLE;
      end
      default: state_next = K_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= K_IDLE;
      qcnt        <= '0;
      dcol_sync   <= '0;
      drow_sync   <= '0;
      col_shift   <= '0;
      row_shift   <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      overrun     <= 1'b0;
      latch_valid <= 1'b0;
      count_err   <= 1'b0;
    end else begin
      state       <= state_next;
      qcnt        <= qcnt_next;
      dcol_sync   <= {dcol_sync[SYNC_STAGES-2:0], link.i_data_col};
      drow_sync   <= {drow_sync[SYNC_STAGES-2:0], link.i_data_row};
      col_shift   <= col_shift_next;
      row_shift   <= row_shift_next;
      latch_valid <= do_latch;
      count_err   <= do_latch & ((col_cnt_next != CCW'(N_COL)) |
                                 (row_cnt_next != RCW'(N_ROW)));
      if (do_latch) begin
        // Next-state values so a bit arriving in the latch cycle is kept.
        col_q   <= col_shift_next;
        row_q   <= row_shift_next;
        col_cnt <= '0;
        row_cnt <= '0;
        overrun <= 1'b0;
      end else begin
        col_cnt <= col_cnt_next;
        row_cnt <= row_cnt_next;
        overrun <= overrun | col_ovr | row_ovr;
      end
    end
  end

  assign link.o_col_shift   = col_shift;
  assign link.o_row_shift   = row_shift;
  assign link.o_col_q       = col_q;
  assign link.o_row_q       = row_q;
  assign link.o_latch_valid = latch_valid;
  assign link.o_count_err   = count_err;
  assign link.o_overrun     = overrun;
  assign link.key_state     = state;
  assign link.sync_levels   = {key_level, row_level, col_level};

endmodule

// File: doc/chip_link_receiver.md
# chip_link_receiver

Chip-side receiver for the serial sensor-configuration link produced by `chip_driver`. It oversamples `o_clk_col`/`o_data_col`, `o_clk_row`/`o_data_row` and `o_write_key` with the system clock and shifts the serial data into column and row shift registers. On a qualified write-key pulse it latches both registers into output holding registers and checks the bit counts. It serves as the loopback monitor in the controller FPGA and as the synthesizable chip model in system benches.

## Interface
- `N_COL`, default 16: column shift-register length in bits.
- `N_ROW`, default 16: row shift-register length in bits.
- `KEY_MIN`, default 2: synchronized clk cycles write-key must stay high before it is accepted.
- `clk` in, 1: system clock.
- `rst` in, 1: reset, asynchronous, active-low.
- `i_clk_col` in, 1: serial column clock; asynchronous to `clk`.
- `i_data_col` in, 1: serial column data.
- `i_clk_row` in, 1: serial row clock.
- `i_data_row` in, 1: serial row data.
- `i_write_key` in, 1: latch strobe, active-high.
- `o_col_shift` out, N_COL: live column shift register.
- `o_row_shift` out, N_ROW: live row shift register.
- `o_col_q` out, N_COL: column word latched at the last accepted key.
- `o_row_q` out, N_ROW: row word latched at the last accepted key.
- `o_latch_valid` out, 1: one-cycle pulse when `o_col_q`/`o_row_q` update.
- `o_count_err` out, 1: valid with `o_latch_valid`; 1 if the column count ≠ N_COL or the row count ≠ N_ROW.
- `o_overrun` out, 1: sticky; set when more than N bits are shifted into either register since the last latch.

## Operation
- All five inputs pass through 2-flop synchronizers.
- Rising-edge detect runs on the synchronized `i_clk_col`, `i_clk_row` and `i_write_key`.
- Data lines use the same sync depth as their clocks, so data is sampled at the serial-clock rising edge.
- Shift on a col/row edge:
  - `shift <= {shift[N-2:0], data}`: the new bit enters bit 0, and the first bit sent ends up at the MSB after N bits.
  - The bit counter increments and saturates at N.
  - An edge arriving while the count is already N sets `o_overrun`; the shift still occurs.
- Key FSM:
  - K_IDLE → K_QUAL on a synchronized key rising edge; the qualify counter is cleared.
  - K_QUAL → K_IDLE if the key drops before KEY_MIN cycles; nothing is latched and this is not an error.
  - K_QUAL → K_LATCH when the key has been high KEY_MIN cycles.
  - K_LATCH (one cycle) → K_HELD.
  - K_HELD → K_IDLE when the key goes low.
- Actions in K_LATCH:
  - `o_col_q`/`o_row_q` take the shift-register next-state values, so a bit shifted in the same cycle is included.
  - `o_latch_valid` = 1 and `o_count_err` is evaluated.
  - Both counters clear to 0 and `o_overrun` clears.
  - Shift registers are not cleared.
- Simultaneous col and row edges are independent and both are applied in the same cycle.

## Timing
- Reset state: all outputs 0, counters 0, FSM K_IDLE.
- Reset mid-frame discards the partial frame.
- Serial input to `o_*_shift` update: 3 clk cycles after the input rising edge (2 sync + 1 edge register).
- Serial clock high and low phases must each be ≥ 3 clk cycles. Narrower pulses may be missed; this is not detected.
- Key accept: `o_latch_valid` asserts 3 + KEY_MIN clk cycles after `i_write_key` rises.
- `o_count_err` is only meaningful while `o_latch_valid` = 1 and reads 0 otherwise.
- A key held high indefinitely produces exactly one latch.
- A new latch requires the key to go low and then high again.

## Structure
- `chip_link_pkg` holds:
  - the key FSM state enum (K_IDLE, K_QUAL, K_LATCH, K_HELD);
  - `SYNC_STAGES = 2`;
  - the count-width function `$clog2(N+1)`.
- Sub-module `edge_sync`: SYNC_STAGES synchronizer with a registered rising-edge pulse output and a synchronized level output. It is instantiated for `i_clk_col`, `i_clk_row` and `i_write_key`.
- Data lines use plain sync stages.

## Test plan
- Reset mid-frame: shift 5 column bits, assert `rst` = 0 → all outputs 0; a following 16-bit frame latches cleanly with `o_count_err` = 0.
- Column frame plus key: 16 column bits of 0xA5C3 MSB-first (serial clk period 8 clk), then a key high for 4 clk → `o_col_q` = 0xA5C3, `o_latch_valid` one cycle, `o_count_err` = 0.
- Short frame: 12 row bits, then a key → `o_count_err` = 1, `o_row_q` = previous contents shifted by 12, row count cleared.
- Overrun: 17 column bits → `o_overrun` = 1 after the 17th edge, `o_col_q` holds the last 16 bits at the key, `o_overrun` = 0 after the latch.
- Key glitch: key high 1 clk with KEY_MIN = 2 → no `o_latch_valid`. Then a key held high 100 clk → exactly one pulse.
- Simultaneous events: a column edge and a key edge synchronized in the same cycle, with row and column edges coincident → the latched word includes the coincident bit and both registers shift.
